spi_rom_target: RTL and testbench
=================================

Name: spi_rom_target

Overview:
- SPI mode-0 target (responder): the far end of the SoC's spi0 master link (MISO/MOSI/SCLK/SS_n).
- Lets the board's SPI master, or a second board, stream bytes out of an on-chip byte memory (cartridge ROM image) with a FAST-READ style protocol.
- Runs entirely in the system clock domain: SCLK, MOSI and SS_n are oversampled.
- Sits between the spi0 pins and a simple byte-wide memory read port.

Parameters:
- ADDR_W, 16, memory address width; the address is sent MSB-first in 2 bytes, and bits above ADDR_W are ignored.
- ID_BYTE, 8'hB5, byte returned by the ID command.
- SYNC_STAGES, 2, synchroniser depth on SCLK/MOSI/SS_n (minimum 2).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- spi_SCLK  in  1  SPI clock from the master, asynchronous, idles low (mode 0).
- spi_MOSI  in  1  master-out data, asynchronous.
- spi_SS_n  in  1  active-low target select, asynchronous.
- spi_MISO  out  1  target-out data, registered.
- spi_MISO_oe  out  1  output enable for the MISO pad; high only while selected.
- mem_addr  out  ADDR_W  read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data.
- mem_rdvalid  in  1  qualifies mem_rdata; arrives 1 to 8 clk after mem_rd.
- busy  out  1  high while SS_n is synchronised low.
- last_cmd  out  8  most recent command byte received.
- underrun  out  1  sticky; set when a data byte was not ready at its load point.

Behaviour:
- Reset values:
  - spi_MISO=1, spi_MISO_oe=0, mem_rd=0, mem_addr=0.
  - busy=0, last_cmd=8'h00, underrun=0.
  - FSM in IDLE, bit counter 0, synchronisers all 1 (SCLK stages 0).
- Reset asserted mid-transfer aborts immediately. The FSM restarts in IDLE and waits for a new SS_n fall.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - rise/fall/ss_fall/ss_rise are one-cycle pulses derived from the last two synchronised stages.
  - The master guarantees SCLK <= clk_clk/8 and SS_n setup/hold >= 1 SCLK period.
- Bit timing:
  - MOSI is sampled on `rise`.
  - MISO changes on `fall`, registered 1 clk after the fall pulse.
  - Bytes are MSB first.
  - The 3-bit bit counter increments on `rise`; a byte completes on the rise where the counter wraps 7->0.
- spi_MISO_oe = busy. spi_MISO = 1 whenever not shifting real data.
- FSM states:
  - IDLE -> CMD on ss_fall.
  - CMD: on byte completion, latch last_cmd.
    - 8'h0B -> ADDR_HI.
    - 8'h9F -> ID.
    - Anything else -> IGNORE.
  - ADDR_HI: byte completes -> ADDR_LO; store the high address byte.
  - ADDR_LO: byte completes -> DUMMY; form the start address and pulse mem_rd with mem_addr=start in the same clk as the completing rise.
  - DUMMY: MOSI is ignored and MISO=1. On byte completion -> DATA, and load the prefetched byte into the TX shift register.
  - DATA:
    - Each byte load pulses mem_rd for address+1 (prefetch).
    - mem_rdvalid captures into a holding register, which sets a `ready` flag.
    - At the next load point, if ready=0 the shift register is loaded with 8'hFF and underrun is set.
  - Address increments modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000.
  - ID: the shift register is loaded with ID_BYTE at every byte boundary, indefinitely.
  - IGNORE: MISO=1 until ss_rise.
- Shift/load timing: the first MISO bit of a loaded byte is driven on the fall that follows the completing rise. Later falls shift left, filling with 1.
- ss_rise in any state -> IDLE next clk:
  - busy=0, MISO=1, oe=0, bit counter cleared, ready cleared.
  - A pending mem_rdvalid after deselect is discarded.
- Simultaneous events:
  - ss_rise wins over rise/fall in the same clk.
  - mem_rdvalid in the same clk as a load point counts as ready; the byte is used and no underrun is flagged.
- SCLK edges while deselected are ignored.
- An SS_n fall while busy is impossible (SS_n is already low).

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, CMD, ADDR_HI, ADDR_LO, DUMMY, DATA, ID, IGNORE);
  - constants CMD_FAST_READ=8'h0B, CMD_READ_ID=8'h9F, IDLE_FILL=8'hFF.
- One natural sub-module: spi_pin_sync. It holds the SYNC_STAGES synchroniser plus the rise/fall pulse generation and is instantiated for SCLK, MOSI and SS_n.

Test Plan:
- Read ID: send 9F, then clock 2 bytes -> MISO reads B5,B5; last_cmd=9F; mem_rd never pulses.
- Fast read: send 0B 12 34 00, memory[1234..1236]=AA,55,C3, clock 3 bytes -> MISO AA,55,C3; mem_rd pulses at 1234,1235,1236,1237.
- Wrap: send 0B FF FF 00, clock 2 bytes with mem[FFFF]=11, mem[0000]=22 -> MISO 11,22; mem_addr wraps to 0000.
- Underrun: memory latency 200 clk at SCLK=clk/8 -> first data byte FF and underrun=1. Issuing reset then clears underrun.
- Abort and unknown command:
  - Raise SS_n after 3 bits of ADDR_LO -> busy=0, oe=0, MISO=1 within SYNC_STAGES+1 clk; next transaction 9F returns B5.
  - Command 8'h77 -> MISO all FF; last_cmd=77.
- Reset mid-DATA: assert reset_reset for 1 clk -> all outputs at reset values next clk; a following 0B 00 10 00 read returns mem[0010].

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding and command constants for the SPI ROM target.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    DUMMY,
    DATA,
    ID,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_READ_ID   = 8'h9F;
  localparam logic [7:0] IDLE_FILL     = 8'hFF;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with one-cycle
// rise/fall pulses taken from the two oldest stages.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
  assign o_fall  = ~r_sync[SYNC_STAGES-2] & r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rom_target.sv
// SPI mode-0 target streaming bytes from a byte-wide memory port using a
// FAST-READ (0B) protocol, plus a fixed ID response (9F).
module spi_rom_target
  import spi_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] ID_BYTE     = 8'hB5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_SS_n,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rdvalid,
  output logic              busy,
  output logic [7:0]        last_cmd,
  output logic              underrun
);

  logic w_sck_rise, w_sck_fall, w_unused_sck_level;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_ss_rise, w_ss_fall, w_unused_ss_level;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk_clk), .i_reset(reset_reset), .i_pin(spi_SCLK),
    .o_level(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
    .i_clk(clk_clk), .i_reset(reset_reset), .i_pin(spi_MOSI),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clk(clk_clk), .i_reset(reset_reset), .i_pin(spi_SS_n),
    .o_level(w_unused_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  state_t            r_state, w_next_state;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_miso;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_addr_hi;
  logic              r_mem_rd;
  logic [7:0]        r_hold;
  logic              r_ready;
  logic [7:0]        r_last_cmd;
  logic              r_underrun;

  logic              w_active, w_byte_done, w_capture, w_underrun_set;
  logic              w_id_load, w_data_load, w_fetch;
  logic [7:0]        w_rx_byte, w_load_byte;
  logic [ADDR_W-1:0] w_fetch_addr;

  assign w_active    = (r_state != IDLE);
  assign w_rx_byte   = {r_rx, w_mosi};
  // Deselect outranks any SCLK edge seen in the same clock.
  assign w_byte_done = w_active && w_sck_rise && (r_bit_cnt == 3'd7) && !w_ss_rise;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_ss_rise) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_ss_fall) w_next_state = CMD;
        CMD: begin
          if (w_byte_done) begin
            if (w_rx_byte == CMD_FAST_READ)    w_next_state = ADDR_HI;
            else if (w_rx_byte == CMD_READ_ID) w_next_state = ID;
            else                               w_next_state = IGNORE;
          end
        end
        ADDR_HI: if (w_byte_done) w_next_state = ADDR_LO;
        ADDR_LO: if (w_byte_done) w_next_state = DUMMY;
        DUMMY:   if (w_byte_done) w_next_state = DATA;
        default: w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    w_id_load    = 1'b0;
    w_data_load  = 1'b0;
    w_fetch      = 1'b0;
    w_fetch_addr = r_addr + ADDR_W'(1);
    case (r_state)
      CMD:     w_id_load = w_byte_done && (w_rx_byte == CMD_READ_ID);
      ID:      w_id_load = w_byte_done;
      ADDR_LO: begin
        w_fetch      = w_byte_done;
        w_fetch_addr = ADDR_W'({r_addr_hi, w_rx_byte});
      end
      DUMMY, DATA: begin
        w_data_load = w_byte_done;
        w_fetch     = w_byte_done;
      end
      default: w_fetch = 1'b0;
    endcase
    // A response landing on the load clock itself is used directly.
    w_load_byte = ID_BYTE;
    if (w_data_load) begin
      if (mem_rdvalid)  w_load_byte = mem_rdata;
      else if (r_ready) w_load_byte = r_hold;
      else              w_load_byte = IDLE_FILL;
    end
    w_underrun_set = w_data_load && !r_ready && !mem_rdvalid;
    w_capture      = mem_rdvalid && !w_ss_rise && ((r_state == DUMMY) || (r_state == DATA));
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_bit_cnt  <= 3'd0;
      r_rx       <= 7'd0;
      r_tx       <= IDLE_FILL;
      r_miso     <= 1'b1;
      r_addr     <= '0;
      r_addr_hi  <= 8'h00;
      r_mem_rd   <= 1'b0;
      r_hold     <= 8'h00;
      r_ready    <= 1'b0;
      r_last_cmd <= 8'h00;
      r_underrun <= 1'b0;
    end else begin
      r_mem_rd <= w_fetch;
      if (w_fetch) r_addr <= w_fetch_addr;
      if (w_underrun_set) r_underrun <= 1'b1;
      if ((r_state == CMD) && w_byte_done) r_last_cmd <= w_rx_byte;
      if ((r_state == ADDR_HI) && w_byte_done) r_addr_hi <= w_rx_byte;
      if (w_ss_rise) begin
        r_bit_cnt <= 3'd0;
        r_ready   <= 1'b0;
        r_miso    <= 1'b1;
        r_tx      <= IDLE_FILL;
      end else if (w_active) begin
        if (w_sck_rise) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_rx      <= {r_rx[5:0], w_mosi};
        end
        if (w_sck_fall) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b1};
        end else if (w_id_load || w_data_load) begin
          r_tx <= w_load_byte;
        end
        if (w_data_load) begin
          r_ready <= 1'b0;
        end else if (w_capture) begin
          r_hold  <= mem_rdata;
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign spi_MISO    = r_miso;
  assign busy        = w_active;
  assign spi_MISO_oe = w_active;
  assign mem_addr    = r_addr;
  assign mem_rd      = r_mem_rd;
  assign last_cmd    = r_last_cmd;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_spi_rom_target.sv
// Directed testbench for spi_rom_target: an SPI master at clk/8 plus a
// byte memory responder with adjustable latency.
module tb_spi_rom_target;

  logic        clk_clk = 1'b0;
  logic        reset_reset, spi_SCLK, spi_MOSI, spi_SS_n;
  logic        spi_MISO, spi_MISO_oe, mem_rd, busy, underrun;
  logic        mem_rdvalid = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  last_cmd;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [7:0]  mem [0:65535];
  int          mem_latency = 3;
  logic [15:0] pend_addr = 16'h0000;
  int          pend_cnt = 0;
  logic        pend_active = 1'b0;
  logic [15:0] rd_log [0:255];
  int          rd_count = 0;

  spi_rom_target #(.ADDR_W(16), .ID_BYTE(8'hB5), .SYNC_STAGES(2)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI), .spi_SS_n(spi_SS_n),
    .spi_MISO(spi_MISO), .spi_MISO_oe(spi_MISO_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rdvalid(mem_rdvalid),
    .busy(busy), .last_cmd(last_cmd), .underrun(underrun)
  );

  always #5 clk_clk = ~clk_clk;

  // Single outstanding read; a new strobe replaces any pending one.
  always @(posedge clk_clk) begin
    mem_rdvalid <= 1'b0;
    if (mem_rd) begin
      pend_addr   <= mem_addr;
      pend_cnt    <= mem_latency;
      pend_active <= 1'b1;
    end else if (pend_active) begin
      if (pend_cnt <= 1) begin
        mem_rdvalid <= 1'b1;
        mem_rdata   <= mem[pend_addr];
        pend_active <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  always @(posedge clk_clk) begin
    if (mem_rd) begin
      rd_log[rd_count % 256] <= mem_addr;
      rd_count <= rd_count + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic spi_select();
    spi_SS_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic spi_deselect();
    wait_clk(8);
    spi_SS_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_MOSI = tx[i];
      wait_clk(4);
      spi_SCLK = 1'b1;
      rx[i] = spi_MISO;
      wait_clk(4);
      spi_SCLK = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset_reset = 1'b1;
    wait_clk(1);
    reset_reset = 1'b0;
  endtask

  task automatic test_reset();
    spi_SS_n = 1'b1; spi_SCLK = 1'b0; spi_MOSI = 1'b0;
    reset_reset = 1'b1;
    wait_clk(3);
    if (spi_MISO !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_miso: got %b want 1", spi_MISO); end
    n_compared++;
    if (spi_MISO_oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_oe: got %b want 0", spi_MISO_oe); end
    n_compared++;
    if (mem_rd !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_rd: got %b want 0", mem_rd); end
    n_compared++;
    if (mem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_compared++;
    if (last_cmd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_last_cmd: got %h want 00", last_cmd); end
    n_compared++;
    if (underrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_underrun: got %b want 0", underrun); end
    n_compared++;
    reset_reset = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_read_id();
    logic [7:0] rx;
    int base;
    base = rd_count;
    spi_select();
    if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL id_busy: got %b want 1", busy); end
    n_compared++;
    spi_bits(8'h9F, 8, rx);
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'hB5) begin n_mismatched++; $display("[TB] FAIL id_byte0: got %h want b5", rx); end
    n_compared++;
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'hB5) begin n_mismatched++; $display("[TB] FAIL id_byte1: got %h want b5", rx); end
    n_compared++;
    if (last_cmd !== 8'h9F) begin n_mismatched++; $display("[TB] FAIL id_last_cmd: got %h want 9f", last_cmd); end
    n_compared++;
    if (spi_MISO_oe !== 1'b1) begin n_mismatched++; $display("[TB] FAIL id_oe: got %b want 1", spi_MISO_oe); end
    n_compared++;
    spi_deselect();
    if (rd_count !== base) begin n_mismatched++; $display("[TB] FAIL id_no_mem_rd: got %0d reads want 0", rd_count - base); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL id_busy_after: got %b want 0", busy); end
    n_compared++;
  endtask

  task automatic test_fast_read();
    logic [7:0] rx;
    logic [7:0] exp_data [0:2];
    int base;
    exp_data[0] = 8'hAA; exp_data[1] = 8'h55; exp_data[2] = 8'hC3;
    mem[16'h1234] = 8'hAA; mem[16'h1235] = 8'h55; mem[16'h1236] = 8'hC3; mem[16'h1237] = 8'h0F;
    base = rd_count;
    spi_select();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h12, 8, rx);
    spi_bits(8'h34, 8, rx);
    spi_bits(8'h00, 8, rx);
    for (int k = 0; k < 3; k++) begin
      spi_bits(8'hFF, 8, rx);
      if (rx !== exp_data[k]) begin n_mismatched++; $display("[TB] FAIL fast_data%0d: got %h want %h", k, rx, exp_data[k]); end
      n_compared++;
    end
    spi_deselect();
    for (int k = 0; k < 4; k++) begin
      if (rd_log[(base + k) % 256] !== 16'h1234 + 16'(k)) begin
        n_mismatched++;
        $display("[TB] FAIL fast_rd_addr%0d: got %h want %h", k, rd_log[(base + k) % 256], 16'h1234 + 16'(k));
      end
      n_compared++;
    end
    if (last_cmd !== 8'h0B) begin n_mismatched++; $display("[TB] FAIL fast_last_cmd: got %h want 0b", last_cmd); end
    n_compared++;
    if (underrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fast_underrun: got %b want 0", underrun); end
    n_compared++;
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    int base;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22; mem[16'h0001] = 8'h33;
    base = rd_count;
    spi_select();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'h11) begin n_mismatched++; $display("[TB] FAIL wrap_data0: got %h want 11", rx); end
    n_compared++;
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'h22) begin n_mismatched++; $display("[TB] FAIL wrap_data1: got %h want 22", rx); end
    n_compared++;
    spi_deselect();
    if (rd_log[(base + 1) % 256] !== 16'h0000) begin
      n_mismatched++; $display("[TB] FAIL wrap_rd_addr: got %h want 0000", rd_log[(base + 1) % 256]);
    end
    n_compared++;
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    mem[16'h2000] = 8'h5A;
    mem_latency = 200;
    spi_select();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL underrun_data: got %h want ff", rx); end
    n_compared++;
    if (underrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL underrun_flag: got %b want 1", underrun); end
    n_compared++;
    spi_deselect();
    wait_clk(300);
    mem_latency = 3;
    pulse_reset();
    if (underrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL underrun_cleared: got %b want 0", underrun); end
    n_compared++;
    wait_clk(4);
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int base;
    base = rd_count;
    spi_select();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h12, 8, rx);
    spi_bits(8'h34, 3, rx);
    wait_clk(8);
    spi_SS_n = 1'b1;
    wait_clk(3);
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    n_compared++;
    if (spi_MISO_oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_oe: got %b want 0", spi_MISO_oe); end
    n_compared++;
    if (spi_MISO !== 1'b1) begin n_mismatched++; $display("[TB] FAIL abort_miso: got %b want 1", spi_MISO); end
    n_compared++;
    if (rd_count !== base) begin n_mismatched++; $display("[TB] FAIL abort_no_mem_rd: got %0d reads want 0", rd_count - base); end
    n_compared++;
    wait_clk(10);
    spi_select();
    spi_bits(8'h9F, 8, rx);
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'hB5) begin n_mismatched++; $display("[TB] FAIL abort_then_id: got %h want b5", rx); end
    n_compared++;
    spi_deselect();
  endtask

  task automatic test_ignore();
    logic [7:0] rx;
    spi_select();
    spi_bits(8'h77, 8, rx);
    spi_bits(8'h00, 8, rx);
    if (rx !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL ignore_byte0: got %h want ff", rx); end
    n_compared++;
    spi_bits(8'h00, 8, rx);
    if (rx !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL ignore_byte1: got %h want ff", rx); end
    n_compared++;
    if (last_cmd !== 8'h77) begin n_mismatched++; $display("[TB] FAIL ignore_last_cmd: got %h want 77", last_cmd); end
    n_compared++;
    spi_deselect();
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] rx;
    spi_select();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h12, 8, rx);
    spi_bits(8'h34, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'hAA) begin n_mismatched++; $display("[TB] FAIL middata_first: got %h want aa", rx); end
    n_compared++;
    spi_bits(8'hFF, 4, rx);
    pulse_reset();
    spi_SS_n = 1'b1;
    spi_SCLK = 1'b0;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL middata_busy: got %b want 0", busy); end
    n_compared++;
    if (spi_MISO_oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL middata_oe: got %b want 0", spi_MISO_oe); end
    n_compared++;
    if (spi_MISO !== 1'b1) begin n_mismatched++; $display("[TB] FAIL middata_miso: got %b want 1", spi_MISO); end
    n_compared++;
    if (mem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL middata_addr: got %h want 0000", mem_addr); end
    n_compared++;
    if (last_cmd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL middata_last_cmd: got %h want 00", last_cmd); end
    n_compared++;
    wait_clk(12);
    mem[16'h0010] = 8'h9C; mem[16'h0011] = 8'h47;
    spi_select();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 8, rx);
    if (rx !== 8'h9C) begin n_mismatched++; $display("[TB] FAIL middata_reread: got %h want 9c", rx); end
    n_compared++;
    spi_deselect();
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_fast_read();
    test_wrap();
    test_underrun();
    test_abort();
    test_ignore();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
